// File: rtl/led_pattern_sequencer_if.sv
// Key/LED bundle between the board I/O and the pattern sequencer.
// The slave side is the sequencer; the master side drives the raw keys.
interface led_pattern_sequencer_if;
  logic [1:0] key;
  logic [9:0] led;
  logic [1:0] mode;
  logic       running;

  modport master (output key, input led, mode, running);
  modport slave  (input key, output led, mode, running);
endinterface

// File: rtl/led_pattern_sequencer.sv
// Two-key LED pattern sequencer: per-key sync/debounce, run/stop FSM,
// step prescaler and bounce / binary-count / fill patterns on 10 LEDs.

module led_key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic          db;
  logic [CW-1:0] cnt;

  // press is registered on the same edge the debounced state falls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      db    <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_raw};
      press <= 1'b0;
      if (sync[1] == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db    <= sync[1];
        cnt   <= '0;
        press <= ~sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module led_pattern_sequencer #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int STEP_CYCLES     = 5000000
) (
  input logic               clk,
  input logic               rst,
  led_pattern_sequencer_if.slave bus
);
  localparam int NUM_KEYS = 2;
  localparam int PW       = $clog2(STEP_CYCLES + 1);
  localparam logic [1:0] M_BOUNCE = 2'd0;
  localparam logic [1:0] M_COUNT  = 2'd1;
  localparam logic [1:0] M_FILL   = 2'd2;

  typedef enum logic {STOPPED, RUNNING} run_t;

  logic [NUM_KEYS-1:0] press;
  run_t                state, state_nxt;
  logic                running;
  logic [PW-1:0]       psc;
  logic                tick;
  logic [9:0]          led_q, led_step;
  logic [1:0]          mode_q, mode_nx;
  logic                dir_q, dir_step;   // 0 = left, 1 = right

  genvar g;
  generate
    for (g = 0; g < NUM_KEYS; g++) begin : g_key
      led_key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk     (clk),
        .rst     (rst),
        .key_raw (bus.key[g]),
        .press   (press[g])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= STOPPED;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (press[0]) state_nxt = (state == RUNNING) ? STOPPED : RUNNING;
  end

  always_comb begin
    running = (state == RUNNING);
  end

  assign tick = running && (psc == PW'(STEP_CYCLES - 1));

  // mode 3 is never produced; it advances as if it were BOUNCE
  always_comb begin
    case (mode_q)
      M_COUNT: mode_nx = M_FILL;
      M_FILL:  mode_nx = M_BOUNCE;
      default: mode_nx = M_COUNT;
    endcase
  end

  always_comb begin
    led_step = led_q;
    dir_step = dir_q;
    case (mode_q)
      M_BOUNCE: begin
        if (led_q == '0) begin
          led_step = 10'd1;
        end else if (!dir_q) begin
          if (led_q[9]) begin
            led_step = led_q >> 1;
            dir_step = 1'b1;
          end else begin
            led_step = led_q << 1;
          end
        end else begin
          if (led_q[0]) begin
            led_step = led_q << 1;
            dir_step = 1'b0;
          end else begin
            led_step = led_q >> 1;
          end
        end
      end
      M_COUNT: led_step = led_q + 10'd1;
      M_FILL:  led_step = (&led_q) ? 10'd0 : {led_q[8:0], 1'b1};
      default: led_step = led_q;
    endcase
  end

  // a mode press outranks a coincident tick, which is dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q  <= 10'd1;
      mode_q <= M_BOUNCE;
      dir_q  <= 1'b0;
      psc    <= '0;
    end else if (press[1]) begin
      mode_q <= mode_nx;
      led_q  <= (mode_nx == M_BOUNCE) ? 10'd1 : 10'd0;
      dir_q  <= 1'b0;
      psc    <= '0;
    end else if (running) begin
      psc <= tick ? '0 : psc + 1'b1;
      if (tick) begin
        led_q <= led_step;
        dir_q <= dir_step;
      end
    end
  end

  assign bus.led     = led_q;
  assign bus.mode    = mode_q;
  assign bus.running = running;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Bench for led_pattern_sequencer: directed plan steps plus random key
// activity, checked every cycle against a step-count pattern model.
module tb_led_pattern_sequencer;
  localparam int D = 4;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  led_pattern_sequencer_if bus();

  led_pattern_sequencer #(.DEBOUNCE_CYCLES(D), .STEP_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int nvec = 0;
  int nerr = 0;

  // model: key path per the debounce rule, pattern as a function of steps
  logic [1:0] m_s1, m_s2, m_db, m_pend;
  int         m_cnt [2];
  int         m_mode, m_steps, m_phase;
  bit         m_run;

  function automatic logic [9:0] pat(input int md, input int st);
    int p;
    case (md)
      1: return 10'(st % 1024);
      2: begin p = st % 11; return 10'((1 << p) - 1); end
      default: begin
        p = st % 18;
        if (p > 9) p = 18 - p;
        return 10'(1 << p);
      end
    endcase
  endfunction

  task automatic model_reset();
    m_s1 = 2'b11; m_s2 = 2'b11; m_db = 2'b11; m_pend = 2'b00;
    m_cnt[0] = 0; m_cnt[1] = 0;
    m_mode = 0; m_steps = 0; m_phase = 0; m_run = 1'b0;
  endtask

  task automatic model_edge(input logic [1:0] k);
    bit tk;
    tk = m_run && (m_phase == S - 1);
    if (m_pend[1]) begin
      m_mode = (m_mode + 1) % 3; m_steps = 0; m_phase = 0;
    end else if (m_run) begin
      m_phase = (m_phase + 1) % S;
      if (tk) m_steps++;
    end
    if (m_pend[0]) m_run = !m_run;
    m_pend = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (m_s2[i] == m_db[i]) m_cnt[i] = 0;
      else begin
        m_cnt[i]++;
        if (m_cnt[i] == D) begin
          m_cnt[i] = 0; m_db[i] = m_s2[i]; m_pend[i] = ~m_s2[i];
        end
      end
    end
    m_s2 = m_s1; m_s1 = k;
  endtask

  task automatic expv(input string tag, input logic [9:0] got, input logic [9:0] want);
    nvec++;
    assert (got === want) else begin
      nerr++;
      $error("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  task automatic check_model(input string tag);
    expv({tag, ".led"}, bus.led, pat(m_mode, m_steps));
    expv({tag, ".mode"}, {8'd0, bus.mode}, 10'(m_mode));
    expv({tag, ".running"}, {9'd0, bus.running}, {9'd0, m_run});
  endtask

  task automatic cyc(input logic [1:0] k);
    bus.key = k;
    @(posedge clk);
    model_edge(k);
    @(negedge clk);
    check_model("cyc");
  endtask

  task automatic press(input logic [1:0] k);
    repeat (8) cyc(k);
    repeat (8) cyc(2'b11);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    expv("async_rst.led", bus.led, 10'b0000000001);
    expv("async_rst.mode", {8'd0, bus.mode}, 10'd0);
    expv("async_rst.running", {9'd0, bus.running}, 10'd0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_model("post_rst");
  endtask

  logic [9:0] frozen;
  bit         saw_full, wrapped;
  logic [1:0] rk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key = 2'b11;
    #2;
    do_reset();

    // short glitch on key[0] must be rejected
    for (int i = 1; i <= 3; i++) cyc(2'b10);
    repeat (8) cyc(2'b11);
    expv("glitch.running", {9'd0, bus.running}, 10'd0);

    // held start press: latency and BOUNCE sequence
    for (int i = 1; i <= 70; i++) begin
      cyc(i <= 20 ? 2'b10 : 2'b11);
      if (i == 6)  expv("lat6.running", {9'd0, bus.running}, 10'd0);
      if (i == 7)  expv("lat7.running", {9'd0, bus.running}, 10'd1);
      if (i == 10) expv("bounce.t1", bus.led, 10'b0000000010);
      if (i == 34) expv("bounce.t9", bus.led, 10'b1000000000);
      if (i == 37) expv("bounce.t10", bus.led, 10'b0100000000);
      if (i == 61) expv("bounce.t18", bus.led, 10'b0000000001);
    end

    // COUNT and its wrap
    for (int i = 1; i <= 16; i++) begin
      cyc(i <= 8 ? 2'b01 : 2'b11);
      if (i == 7) begin
        expv("count.mode", {8'd0, bus.mode}, 10'd1);
        expv("count.led0", bus.led, 10'd0);
      end
    end
    saw_full = 1'b0; wrapped = 1'b0;
    for (int i = 0; i < 3300 && !wrapped; i++) begin
      cyc(2'b11);
      if (bus.led == 10'h3ff) saw_full = 1'b1;
      else if (saw_full && bus.led == 10'd0) wrapped = 1'b1;
    end
    expv("count.wrap", {9'd0, wrapped}, 10'd1);

    // asynchronous reset while running COUNT
    do_reset();

    // FILL then stop
    press(2'b01);
    press(2'b01);
    expv("fill.mode", {8'd0, bus.mode}, 10'd2);
    expv("fill.led0", bus.led, 10'd0);
    for (int i = 1; i <= 50; i++) begin
      cyc(i <= 8 ? 2'b10 : 2'b11);
      if (i == 10) expv("fill.t1", bus.led, 10'b0000000001);
      if (i == 37) expv("fill.t10", bus.led, 10'b1111111111);
      if (i == 40) expv("fill.t11", bus.led, 10'b0000000000);
    end
    press(2'b10);
    expv("stop.running", {9'd0, bus.running}, 10'd0);
    frozen = pat(m_mode, m_steps);
    repeat (30) cyc(2'b11);
    expv("stop.frozen", bus.led, frozen);

    // mode press landing on a tick in BOUNCE
    press(2'b01);
    press(2'b10);
    for (int i = 0; i < 10 && !(m_run && m_phase == S - 1); i++) cyc(2'b11);
    for (int i = 1; i <= 16; i++) begin
      cyc(i <= 8 ? 2'b01 : 2'b11);
      if (i == 7) begin
        expv("simul.mode", {8'd0, bus.mode}, 10'd1);
        expv("simul.led", bus.led, 10'd0);
      end
    end

    // both keys together from STOPPED FILL
    press(2'b10);
    press(2'b01);
    for (int i = 1; i <= 16; i++) begin
      cyc(i <= 8 ? 2'b00 : 2'b11);
      if (i == 7) begin
        expv("both.mode", {8'd0, bus.mode}, 10'd0);
        expv("both.led", bus.led, 10'b0000000001);
        expv("both.running", {9'd0, bus.running}, 10'd1);
      end
    end

    // random key activity, with a reset while both keys are held
    for (int b = 0; b < 120; b++) begin
      rk = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 12)) cyc(rk);
    end
    bus.key = 2'b00;
    cyc(2'b00);
    do_reset();
    repeat (12) cyc(2'b00);
    for (int b = 0; b < 120; b++) begin
      rk = 2'($urandom_range(0, 3));
      repeat ($urandom_range(1, 12)) cyc(rk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Key-driven LED pattern controller for the board's 2-key / 10-LED I/O. It synchronizes and debounces the two raw push-buttons and turns them into start/stop and mode-select commands. It runs a run/stop state machine with a step prescaler and drives a 10-bit LED pattern: bounce, binary count or fill. It sits between the board keys and the LED bank, replacing direct combinational key-to-LED logic.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles required before a key state is accepted (5 ms at 50 MHz).
STEP_CYCLES, 5000000, clock cycles per pattern step while running (0.1 s at 50 MHz); minimum 1.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
key  input  2  raw push-buttons, active-low (0 = pressed); key[0] = start/stop, key[1] = mode
led  output 10 LED pattern, 1 = lit
mode output 2  current mode: 0 BOUNCE, 1 COUNT, 2 FILL
running output 1  1 = pattern stepping

Behaviour:
- Reset (async, immediate, no clock needed) values:
  - led=10'b0000000001, mode=0, running=0, direction=left.
  - Prescaler=0, debounce counters=0.
  - Synchronizer flops and debounced key states=1 (released).
- Input path, per key:
  - 2-flop synchronizer.
  - Debounce counter: clears whenever the synchronized value equals the debounced state; otherwise increments. When it reaches DEBOUNCE_CYCLES, the debounced state takes the synchronized value and the counter clears.
  - A 1-to-0 debounced transition produces a one-cycle press pulse. Release produces no event. Holding a key gives exactly one pulse.
- Latency: raw key edge to press pulse = 2 + DEBOUNCE_CYCLES cycles. Register updates occur on the edge after the pulse.
- Run FSM, states STOPPED / RUNNING:
  - Press on key[0] toggles the state. running=1 only in RUNNING.
  - STOPPED: prescaler holds its value; led and direction hold.
- Mode select:
  - Press on key[1] advances mode 0→1→2→0.
  - Loads the new mode's initial pattern, sets direction=left, clears prescaler. Run state is unchanged.
  - Mode value 3 is unreachable; if ever present, treat as 0 on the next mode press.
- Prescaler: in RUNNING, counts 0..STEP_CYCLES-1. At STEP_CYCLES-1 it asserts an internal tick and wraps to 0.
- Step rules on tick:
  - BOUNCE (initial 0000000001): one lit bit.
    - direction=left: shift left. At 1000000000, direction flips to right and the next step gives 0100000000.
    - direction=right: shift right. At 0000000001, direction flips to left and the next step gives 0000000010.
    - No step ever produces 0.
  - COUNT (initial 0): led <= led+1 modulo 1024; 1111111111 wraps to 0000000000.
  - FILL (initial 0): led <= {led[8:0],1'b1}; 1111111111 wraps to 0000000000.
- Simultaneous events:
  - key[1] press and tick in the same cycle: mode change wins and the tick is discarded.
  - key[0] and key[1] presses in the same cycle: both apply (mode advance with pattern load, and run toggle).
  - key[0] press stopping the FSM in the same cycle as a tick: the tick is still applied, then the FSM stops.
- Reset mid-operation: all state returns to reset values immediately. Any key held through reset is seen as a new press once debounced after reset release.

Test Plan:
(Benches override DEBOUNCE_CYCLES=4, STEP_CYCLES=3.)
1. Async reset: assert rst between clock edges during RUNNING COUNT → led=0000000001, mode=0, running=0 before the next clk edge; hold until release.
2. Debounce: key=2'b10 for 3 cycles, then 2'b11 → no pulse, running stays 0. key=2'b10 held 20 cycles → running=1 exactly 7 cycles after the key edge (2 sync + 4 debounce + 1 register), one toggle only.
3. BOUNCE: start running, count ticks every 3 cycles → led 0000000010, 0000000100, …, 1000000000 after 9 ticks, 0100000000 after tick 10, back to 0000000001 after tick 18.
4. COUNT wrap: press key[1] once → mode=1, led=0, prescaler cleared. Run 1024 ticks → led passes 1111111111 and returns to 0000000000.
5. FILL + stop: press key[1] twice from mode 0 → mode=2, led=0. Ticks give 0000000001, 0000000011, …, 1111111111 after tick 10, 0 after tick 11. Press key[0] → running=0 and led frozen across 30 cycles.
6. Simultaneous: time a key[1] press to coincide with a tick in BOUNCE → mode=1, led=0, no shift applied. Press both keys in the same cycle from STOPPED mode 2 → mode=0, led=0000000001, running=1.
